// File: rtl/imm_encoder_pkg.sv
// Shared core package: immediate-format encodings and helpers used by the
// encoder and decoder paths.
package imm_encoder_pkg;

    localparam int DATA_W     = 32;
    localparam int FIFO_DEPTH = 2;
    localparam int ERR_W      = 8;

    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } imm_fmt_e;

    typedef struct packed {
        logic [DATA_W-1:0] instr;
        logic              range_err;
    } fifo_entry_t;

    // True when v is representable as a two's-complement number of 'bits' bits:
    // every bit above the sign position must replicate the sign.
    function automatic logic fits_signed(input logic signed [DATA_W-1:0] v,
                                         input int unsigned bits);
        logic signed [DATA_W-1:0] hi;
        hi = v >>> (bits - 1);
        return (hi == '0) || (hi == '1);
    endfunction

endpackage

// File: rtl/imm_scatter.sv
// Combinational field scatter of a signed immediate into an RV32I word,
// plus the format range/alignment check.
module imm_scatter
    import imm_encoder_pkg::*;
(
    input  logic        [1:0]        imm_src,
    input  logic signed [DATA_W-1:0] imm,
    input  logic        [DATA_W-1:0] instr_base,
    output logic        [DATA_W-1:0] instr,
    output logic                     range_err
);

    always_comb begin
        instr     = instr_base;
        range_err = 1'b0;
        case (imm_fmt_e'(imm_src))
            IMM_I: begin
                instr[31:20] = imm[11:0];
                range_err    = !fits_signed(imm, 12);
            end
            IMM_S: begin
                instr[31:25] = imm[11:5];
                instr[11:7]  = imm[4:0];
                range_err    = !fits_signed(imm, 12);
            end
            // Branch and jump offsets are halfword aligned, so bit 0 is never
            // encoded and must be zero for the word to be meaningful.
            IMM_B: begin
                instr[31]    = imm[12];
                instr[30:25] = imm[10:5];
                instr[11:8]  = imm[4:1];
                instr[7]     = imm[11];
                range_err    = !fits_signed(imm, 13) || imm[0];
            end
            IMM_J: begin
                instr[31]    = imm[20];
                instr[30:21] = imm[10:1];
                instr[20]    = imm[11];
                instr[19:12] = imm[19:12];
                range_err    = !fits_signed(imm, 21) || imm[0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/imm_encoder.sv
// Immediate encoder: scatters the immediate at acceptance, buffers words in a
// 2-entry in-order FIFO, and keeps a saturating count of out-of-range requests.
module imm_encoder
    import imm_encoder_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic        [1:0]        in_imm_src,
    input  logic signed [DATA_W-1:0] in_imm,
    input  logic        [DATA_W-1:0] in_instr_base,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic        [DATA_W-1:0] out_instr,
    output logic                     out_range_err,
    input  logic                     err_clr,
    output logic        [ERR_W-1:0]  err_count
);

    logic [DATA_W-1:0] enc_instr;
    logic              enc_err;

    logic [1:0]        count_q, count_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
    fifo_entry_t       mem_q [FIFO_DEPTH];
    fifo_entry_t       mem_d [FIFO_DEPTH];
    fifo_entry_t       head;

    logic push;
    logic pop;

    imm_scatter u_scatter (
        .imm_src    (in_imm_src),
        .imm        (in_imm),
        .instr_base (in_instr_base),
        .instr      (enc_instr),
        .range_err  (enc_err)
    );

    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Outputs are gated by occupancy so the data storage needs no reset.
    assign head          = mem_q[rd_ptr_q];
    assign out_instr     = out_valid ? head.instr : '0;
    assign out_range_err = out_valid && head.range_err;
    assign err_count     = err_cnt_q;

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = '{instr: enc_instr, range_err: enc_err};
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // A clear that coincides with an accepted error leaves that error counted.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_clr) begin
            err_cnt_d = (push && enc_err) ? ERR_W'(1) : '0;
        end else if (push && enc_err && (err_cnt_q != ERR_MAX)) begin
            err_cnt_d = err_cnt_q + ERR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q   <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            count_q   <= count_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder: directed scenarios followed by random
// traffic, compared against a queue-based reference model.
module tb_imm_encoder;
    import imm_encoder_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_imm_src = 2'b00;
    logic [31:0] in_imm = '0;
    logic [31:0] in_instr_base = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic        out_range_err;
    logic        err_clr = 1'b0;
    logic [7:0]  err_count;

    imm_encoder dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_imm_src    (in_imm_src),
        .in_imm        (in_imm),
        .in_instr_base (in_instr_base),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_instr     (out_instr),
        .out_range_err (out_range_err),
        .err_clr       (err_clr),
        .err_count     (err_count)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] instr;
        logic        err;
    } exp_t;

    exp_t mq[$];
    int   mcnt = 0;

    function automatic logic [31:0] ref_encode(input logic [1:0] src, input int imm,
                                               input logic [31:0] base);
        logic [31:0] u;
        u = imm;
        case (src)
            2'b00:   return (base & 32'h000F_FFFF) | ((u & 32'hFFF) << 20);
            2'b01:   return (base & 32'h01FF_F07F) | (((u >> 5) & 32'h7F) << 25)
                            | ((u & 32'h1F) << 7);
            2'b10:   return (base & 32'h01FF_F07F) | (((u >> 12) & 32'h1) << 31)
                            | (((u >> 5) & 32'h3F) << 25) | (((u >> 1) & 32'hF) << 8)
                            | (((u >> 11) & 32'h1) << 7);
            default: return (base & 32'h0000_0FFF) | (((u >> 20) & 32'h1) << 31)
                            | (((u >> 1) & 32'h3FF) << 21) | (((u >> 11) & 32'h1) << 20)
                            | (((u >> 12) & 32'hFF) << 12);
        endcase
    endfunction

    function automatic logic ref_err(input logic [1:0] src, input int imm);
        case (src)
            2'b00, 2'b01: return (imm < -2048) || (imm > 2047);
            2'b10:        return (imm < -4096) || (imm > 4094) || ((imm & 1) != 0);
            default:      return (imm < -1048576) || (imm > 1048574) || ((imm & 1) != 0);
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("out_valid", {31'b0, out_valid}, {31'b0, mq.size() > 0});
        chk("in_ready", {31'b0, in_ready}, {31'b0, mq.size() < 2});
        chk("err_count", {24'b0, err_count}, mcnt);
        if (mq.size() > 0) begin
            chk("out_instr", out_instr, mq[0].instr);
            chk("out_range_err", {31'b0, out_range_err}, {31'b0, mq[0].err});
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] src, input int imm,
                         input logic [31:0] base, input logic ordy);
        in_valid      = v;
        in_imm_src    = src;
        in_imm        = imm;
        in_instr_base = base;
        out_ready     = ordy;
    endtask

    // One clock: predict transfers from the current inputs, advance, then compare.
    task automatic step();
        bit   push;
        bit   pop;
        exp_t e;
        push    = in_valid && (mq.size() < 2);
        pop     = out_ready && (mq.size() > 0);
        e.instr = ref_encode(in_imm_src, int'(in_imm), in_instr_base);
        e.err   = ref_err(in_imm_src, int'(in_imm));
        @(posedge clk);
        #1;
        if (pop) void'(mq.pop_front());
        if (push) mq.push_back(e);
        if (err_clr) mcnt = (push && e.err) ? 1 : 0;
        else if (push && e.err && mcnt < 255) mcnt++;
        check_outputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int bnd[16] = '{-2048, -2049, 2047, 2048, -4096, -4097, 4094, 4095,
                        4096, -1048576, -1048577, 1048574, 1048575, 1048576, 0, -1};
        int imm;

        // Reset state while rst_n is held low.
        #12;
        chk("rst_out_instr", out_instr, 32'h0);
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;

        // I-type accepted on the first edge after reset release.
        drive(1'b1, IMM_I, -1, 32'h0000_0013, 1'b1);
        step();
        chk("i_type_instr", out_instr, 32'hFFF0_0013);
        chk("i_type_err", {31'b0, out_range_err}, 32'h0);

        drive(1'b1, IMM_S, 32'h7FF, 32'h0000_2023, 1'b1);
        step();
        chk("s_type_instr", out_instr, 32'h7E00_2FA3);
        drive(1'b1, IMM_S, 2048, 32'h0000_2023, 1'b1);
        step();
        chk("s_type_err", {31'b0, out_range_err}, 32'h1);
        chk("s_type_cnt", {24'b0, err_count}, 32'h1);

        drive(1'b1, IMM_B, 3, 32'h0000_0063, 1'b1);
        step();
        chk("b_align_err", {31'b0, out_range_err}, 32'h1);
        drive(1'b1, IMM_J, -2, 32'h0000_006F, 1'b1);
        step();
        chk("j_neg2_err", {31'b0, out_range_err}, 32'h0);

        drive(1'b0, IMM_I, 0, 32'h0, 1'b1);
        step();
        step();

        // Backpressure: third push must wait until space frees up.
        drive(1'b1, IMM_I, 1, 32'h0000_0013, 1'b0);
        step();
        drive(1'b1, IMM_I, 2, 32'h0000_0093, 1'b0);
        step();
        chk("bp_in_ready", {31'b0, in_ready}, 32'h0);
        drive(1'b1, IMM_I, 3, 32'h0000_0113, 1'b0);
        step();
        step();
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) step();

        // Saturating error counter.
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        drive(1'b1, IMM_I, 5000, 32'h0000_0013, 1'b1);
        for (int i = 0; i < 256; i++) step();
        chk("cnt_sat", {24'b0, err_count}, 32'd255);
        for (int i = 0; i < 3; i++) step();
        chk("cnt_hold", {24'b0, err_count}, 32'd255);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("cnt_clr_err", {24'b0, err_count}, 32'd1);

        // Asynchronous reset with two words buffered.
        drive(1'b0, IMM_I, 0, 32'h0, 1'b1);
        step();
        drive(1'b1, IMM_S, 4000, 32'h0000_2023, 1'b0);
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        mq.delete();
        mcnt = 0;
        chk("arst_out_valid", {31'b0, out_valid}, 32'h0);
        chk("arst_err_count", {24'b0, err_count}, 32'h0);
        chk("arst_in_ready", {31'b0, in_ready}, 32'h1);
        chk("arst_out_instr", out_instr, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, IMM_B, -4096, 32'h0000_0063, 1'b1);
        step();

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 4))
                0:       imm = int'($urandom_range(0, 10000)) - 5000;
                1:       imm = bnd[$urandom_range(0, 15)];
                2:       imm = int'($urandom);
                3:       imm = int'($urandom_range(0, 2200000)) - 1100000;
                default: imm = (int'($urandom_range(0, 5000)) - 2500) * 2;
            endcase
            drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), imm,
                  $urandom, $urandom_range(0, 2) != 0);
            err_clr = ($urandom_range(0, 15) == 0);
            step();
        end
        err_clr  = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
